// File: rtl/fpaddtree_pkg.sv
// rtl/fpaddtree_pkg.sv - shared constants, helpers and FSM states for the fp adder-tree accumulator
package fpaddtree_pkg;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {ACC, WAIT, DRAIN, FOLD} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int tree_lat(input int n, input int fpl);
    return clog2(n) * fpl;
  endfunction

endpackage

// File: rtl/fpaddtree_pipe.sv
// rtl/fpaddtree_pipe.sv - zero-padded pipelined fpop adder tree with valid/tag sideband (N >= 2)
module fpaddtree_pipe
  import fpaddtree_pkg::*;
#(
  parameter int DW  = 32,
  parameter int N   = 2,
  parameter int FPL = 1,
  parameter int TGW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            in_vld,
  input  logic [TGW-1:0]  in_tag,
  input  logic [N*DW-1:0] x,
  output logic            out_vld,
  output logic [TGW-1:0]  out_tag,
  output logic [DW-1:0]   sum
);

  localparam int D  = clog2(N);
  localparam int TP = 1 << D;
  localparam int LT = tree_lat(N, FPL);

  // heap layout: leaves at TP..2TP-1, node k sums children 2k and 2k+1
  logic [DW-1:0] node [1:2*TP-1];

  for (genvar i = 0; i < TP; i++) begin : g_leaf
    if (i < N) begin : g_lane
      assign node[TP+i] = x[i*DW +: DW];
    end else begin : g_pad
      assign node[TP+i] = FP_POS_ZERO;
    end
  end

  for (genvar k = 1; k < TP; k++) begin : g_add
    fpop #(.DW(DW), .LAT(FPL)) u_add (
      .clk(clk), .rst(rst), .ena(ena),
      .a(node[2*k]), .b(node[2*k+1]), .r(node[k])
    );
  end

  assign sum = node[1];

  logic [LT-1:0]          vsr;
  logic [LT-1:0][TGW-1:0] tsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsr <= '0;
      tsr <= '0;
    end else if (ena) begin
      vsr[0] <= in_vld;
      tsr[0] <= in_tag;
      for (int i = 1; i < LT; i++) begin
        vsr[i] <= vsr[i-1];
        tsr[i] <= tsr[i-1];
      end
    end
  end

  assign out_vld = vsr[LT-1];
  assign out_tag = tsr[LT-1];

endmodule

// File: rtl/fpop.sv
// rtl/fpop.sv - pipelined binary32 ADD, round-to-nearest-even, denormals flushed to zero
module fpop #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] r
);

  // mantissas carry 3 extra bits: guard, round, sticky
  function automatic logic [31:0] fadd(input logic [31:0] fa, input logic [31:0] fb);
    logic [31:0] hi, lo, res;
    logic [26:0] mh, ml, sh;
    logic [27:0] s;
    logic [24:0] rm;
    logic [22:0] mnt;
    logic        sticky, rup, found;
    int          d, e, lz;
    if (fa[30:0] >= fb[30:0]) begin
      hi = fa; lo = fb;
    end else begin
      hi = fb; lo = fa;
    end
    res = '0; sticky = 1'b0; found = 1'b0; lz = 0;
    if (hi[30:23] == 8'hFF) begin
      if (lo[30:23] == 8'hFF && hi[31] != lo[31]) res = 32'h7FC0_0000;
      else res = hi;
    end else if (hi[30:23] == 8'h00) begin
      res = {hi[31] & lo[31], 31'b0};
    end else if (lo[30:23] == 8'h00) begin
      res = hi;
    end else begin
      mh = {1'b1, hi[22:0], 3'b000};
      ml = {1'b1, lo[22:0], 3'b000};
      d  = int'(hi[30:23]) - int'(lo[30:23]);
      if (d > 26) begin
        sh = 27'd1;
      end else begin
        sh = ml >> d;
        sticky = |(ml & ~({27{1'b1}} << d));
        sh[0] = sh[0] | sticky;
      end
      if (hi[31] == lo[31]) s = {1'b0, mh} + {1'b0, sh};
      else                  s = {1'b0, mh} - {1'b0, sh};
      e = int'(hi[30:23]);
      if (s != '0) begin
        if (s[27]) begin
          s = {1'b0, s[27:2], s[1] | s[0]};
          e = e + 1;
        end else begin
          for (int i = 26; i >= 0; i--) begin
            if (!found && s[i]) begin
              found = 1'b1;
              lz = 26 - i;
            end
          end
          s = s << lz;
          e = e - lz;
        end
        rup = s[2] & (s[1] | s[0] | s[3]);
        rm  = {1'b0, s[26:3]} + 25'(rup);
        mnt = rm[24] ? rm[23:1] : rm[22:0];
        if (rm[24]) e = e + 1;
        if (e <= 0)        res = {hi[31], 31'b0};
        else if (e >= 255) res = {hi[31], 8'hFF, 23'b0};
        else               res = {hi[31], e[7:0], mnt};
      end
    end
    return res;
  endfunction

  logic [LAT-1:0][DW-1:0] stg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg <= '0;
    end else if (ena) begin
      stg[0] <= fadd(a, b);
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
  end

  assign r = stg[LAT-1];

endmodule

// File: rtl/fpaddtree_acc.sv
// rtl/fpaddtree_acc.sv - streaming fp vector reduction: beat tree, interleaved accumulator, slot fold
module fpaddtree_acc
  import fpaddtree_pkg::*;
#(
  parameter int DW  = 32,
  parameter int TW  = 16,
  parameter int FPL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_vld,
  input  logic             in_last,
  output logic             in_rdy,
  input  logic [TW*DW-1:0] x,
  output logic             out_vld,
  output logic [DW-1:0]    out_r
);

  localparam int CW = (FPL > 1) ? clog2(FPL) : 1;

  state_t            state, state_nxt;
  logic              started, accept;
  logic              tree_vld, tree_last;
  logic [DW-1:0]     tree_sum, acc_a, acc_b, acc_out, fold_sum;
  logic [FPL-1:0]    live;
  logic              head, drain, drain_end;
  logic [CW-1:0]     cnt;
  logic [FPL*DW-1:0] pbank;
  logic              fold_go, fold_vld, fold_tag, fold_done;

  assign in_rdy = ena & started & (state == ACC) & ~out_vld;
  assign accept = in_vld & in_rdy;

  fpaddtree_pipe #(.DW(DW), .N(TW), .FPL(FPL), .TGW(1)) u_tree (
    .clk(clk), .rst(rst), .ena(ena),
    .in_vld(accept), .in_tag(in_last), .x(x),
    .out_vld(tree_vld), .out_tag(tree_last), .sum(tree_sum)
  );

  // the accumulator holds FPL interleaved partials; live marks which ring slots carry one
  assign drain     = (state == DRAIN);
  assign head      = live[FPL-1];
  assign drain_end = drain && (cnt == CW'(FPL-1));
  assign acc_a     = (tree_vld && !drain) ? tree_sum : FP_POS_ZERO;
  assign acc_b     = (head && !drain) ? acc_out : FP_POS_ZERO;

  fpop #(.DW(DW), .LAT(FPL)) u_acc (
    .clk(clk), .rst(rst), .ena(ena), .a(acc_a), .b(acc_b), .r(acc_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live    <= '0;
      cnt     <= '0;
      pbank   <= '0;
      fold_go <= 1'b0;
    end else if (ena) begin
      live[0] <= drain ? 1'b0 : (tree_vld | head);
      for (int i = 1; i < FPL; i++) live[i] <= live[i-1];
      if (drain) begin
        pbank[int'(cnt)*DW +: DW] <= head ? acc_out : FP_POS_ZERO;
        cnt <= drain_end ? '0 : cnt + CW'(1);
      end
      fold_go <= drain_end;
    end
  end

  if (FPL > 1) begin : g_fold_tree
    fpaddtree_pipe #(.DW(DW), .N(FPL), .FPL(FPL), .TGW(1)) u_fold (
      .clk(clk), .rst(rst), .ena(ena),
      .in_vld(fold_go), .in_tag(1'b1), .x(pbank),
      .out_vld(fold_vld), .out_tag(fold_tag), .sum(fold_sum)
    );
  end else begin : g_fold_bypass
    assign fold_vld = fold_go;
    assign fold_tag = 1'b1;
    assign fold_sum = pbank;
  end

  assign fold_done = fold_vld & fold_tag;

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && in_last)      state_nxt = WAIT;
      WAIT:    if (tree_vld && tree_last) state_nxt = DRAIN;
      DRAIN:   if (drain_end)              state_nxt = FOLD;
      FOLD:    if (fold_done)              state_nxt = ACC;
      default:                             state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ACC;
      started <= 1'b0;
      out_vld <= 1'b0;
      out_r   <= '0;
    end else if (ena) begin
      state   <= state_nxt;
      started <= 1'b1;
      out_vld <= fold_done;
      if (fold_done) out_r <= fold_sum;
    end
  end

endmodule

// File: tb/tb_fpaddtree_acc.sv
// tb/tb_fpaddtree_acc.sv - scoreboard bench for fpaddtree_acc with integer-valued float reference
module tb_fpaddtree_acc;
  localparam int DW = 32, TW = 5, FPL = 2, LAT = 12;

  logic clk = 1'b0, rst = 1'b0, ena = 1'b1, in_vld = 1'b0, in_last = 1'b0;
  logic in_rdy, out_vld;
  logic [TW*DW-1:0] x = '0;
  logic [DW-1:0] out_r;

  always #5 clk = ~clk;

  fpaddtree_acc #(.DW(DW), .TW(TW), .FPL(FPL)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_vld(in_vld), .in_last(in_last),
    .in_rdy(in_rdy), .x(x), .out_vld(out_vld), .out_r(out_r)
  );

  int n_chk = 0, n_pass = 0, cyc = 0, ecyc = 0, last_out_cyc = 0, acc_cyc = 0;
  logic busy = 1'b0, rdy_bad = 1'b0, rnd_ena = 1'b0;
  logic [31:0] exp_q[$];
  int expc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ena) ecyc <= ecyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  // exact binary32 encoding of an integer with |v| < 2^24
  function automatic logic [31:0] i2f(input int v);
    logic s;
    int unsigned m;
    int p;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return {s, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  function automatic logic [TW*DW-1:0] splat(input int v);
    logic [TW*DW-1:0] d;
    for (int l = 0; l < TW; l++) d[l*DW +: DW] = i2f(v);
    return d;
  endfunction

  task automatic send_beat(input logic [TW*DW-1:0] d, input logic last,
                           input logic [31:0] ev, input int gap);
    logic ok;
    @(negedge clk);
    in_vld = 1'b0;
    repeat (gap) @(negedge clk);
    in_vld = 1'b1; x = d; in_last = last;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      #1;
      if (in_rdy) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", {31'b0, ok}, 32'd1);
      in_vld = 1'b0;
    end else begin
      if (last) begin
        exp_q.push_back(ev);
        expc_q.push_back(ecyc + LAT);
        acc_cyc = cyc + 1;
      end
      @(posedge clk);
      if (last) busy = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out();
    for (int t = 0; t < 200 && busy; t++) @(negedge clk);
    if (busy) begin
      chk("out_timeout", {31'b0, busy}, 32'd0);
      busy = 1'b0;
    end
    @(negedge clk);
  endtask

  // monitor: one pop per new out_vld pulse; a pulse held across ena=0 is the same pulse
  initial begin
    logic prev_ov;
    int prev_e;
    logic [31:0] ev;
    int ee;
    prev_ov = 1'b0; prev_e = -1;
    forever begin
      @(negedge clk);
      if (busy && in_rdy) rdy_bad = 1'b1;
      if (out_vld && !(prev_ov && prev_e == ecyc)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_r, 32'hxxxx_xxxx);
        end else begin
          ev = exp_q.pop_front();
          ee = expc_q.pop_front();
          chk("out_r", out_r, ev);
          chk("latency_ecyc", 32'(ecyc), 32'(ee));
          chk("rdy_low_while_busy", {31'b0, rdy_bad}, 32'd0);
          busy = 1'b0; rdy_bad = 1'b0;
          last_out_cyc = cyc;
        end
      end
      prev_ov = out_vld;
      prev_e = ecyc;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_ena) ena = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [TW*DW-1:0] d;
    int nb, tot, val;

    #2;
    chk("reset_in_rdy", {31'b0, in_rdy}, 32'd0);
    chk("reset_out_vld", {31'b0, out_vld}, 32'd0);
    chk("reset_out_r", out_r, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rdy_after_reset", {31'b0, in_rdy}, 32'd1);

    // single beat 1..5
    for (int l = 0; l < TW; l++) d[l*DW +: DW] = i2f(l + 1);
    send_beat(d, 1'b1, 32'h4170_0000, 0);
    idle();
    wait_out();
    chk("latency_raw_t1", 32'(last_out_cyc - acc_cyc), 32'd11);

    // four back-to-back beats of 1.0
    for (int b = 0; b < 4; b++) send_beat(splat(1), b == 3, 32'h41A0_0000, 0);
    idle();
    wait_out();

    // three beats of 2.0 with gaps, then an ignored 100.0 beat while busy
    send_beat(splat(2), 1'b0, 32'h0, 0);
    send_beat(splat(2), 1'b0, 32'h0, 1);
    send_beat(splat(2), 1'b1, 32'h41F0_0000, 3);
    @(negedge clk);
    in_vld = 1'b1; x = splat(100); in_last = 1'b1;
    repeat (5) @(negedge clk);
    in_vld = 1'b0; in_last = 1'b0;
    wait_out();
    send_beat(splat(1), 1'b1, 32'h40A0_0000, 0);
    idle();
    wait_out();

    // reset mid-vector
    send_beat(splat(3), 1'b0, 32'h0, 0);
    send_beat(splat(3), 1'b0, 32'h0, 0);
    @(negedge clk);
    in_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_in_rdy", {31'b0, in_rdy}, 32'd0);
    chk("midrst_out_vld", {31'b0, out_vld}, 32'd0);
    chk("midrst_out_r", out_r, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_beat(splat(1), 1'b1, 32'h40A0_0000, 0);
    idle();
    wait_out();

    // ena low for 5 cycles during drain
    for (int l = 0; l < TW; l++) d[l*DW +: DW] = i2f(l + 1);
    send_beat(d, 1'b1, 32'h4170_0000, 0);
    @(negedge clk);
    in_vld = 1'b0; in_last = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    wait_out();
    chk("latency_raw_stall", 32'(last_out_cyc - acc_cyc), 32'd16);

    // random vectors, signed integer lanes, random gaps and ena drops
    rnd_ena = 1'b1;
    for (int v = 0; v < 12; v++) begin
      nb = $urandom_range(1, 5);
      tot = 0;
      for (int b = 0; b < nb; b++) begin
        for (int l = 0; l < TW; l++) begin
          val = int'($urandom_range(0, 2000)) - 1000;
          tot += val;
          d[l*DW +: DW] = i2f(val);
        end
        send_beat(d, b == nb - 1, i2f(tot), $urandom_range(0, 2));
      end
      idle();
    end
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) @(negedge clk);
    rnd_ena = 1'b0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
